timing_control: RTL and testbench

TIMING_CONTROL -- requirements
Module: timing_control

---
 rtl/timing_control.sv | 165 ++++++++++++++++
 tb/tb_timing_control.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_control.sv
// Instruction timing controller for a small accumulator CPU: tracks T1..T4,
// latches the opcode and decodes per-cycle bus, address and ALU controls.
//
// state | meaning
// T1    | opcode fetch, ir loaded at end of cycle
// T2    | operand/low-address fetch, immediate execute, NOP/illegal end
// T3    | zero-page memory access, or absolute high-address fetch
// T4    | absolute memory access
module timing_control (
    input  logic       phi2,
    input  logic       rst,
    input  logic       rdy,
    input  logic [7:0] data_in,
    output logic [2:0] t_state,
    output logic [7:0] ir,
    output logic       sync,
    output logic       rw,
    output logic [1:0] ab_sel,
    output logic       pc_inc,
    output logic       lo_ld,
    output logic       hi_ld,
    output logic [2:0] alu_op,
    output logic       ac_load,
    output logic       ac_db,
    output logic       illegal
);

    typedef enum logic [2:0] {
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;
    logic       grp;
    logic       is_imm;
    logic       is_zp;
    logic       is_abs;
    logic       is_sta;
    logic       is_nop;
    logic [2:0] alu_sel;
    logic       stall;
    logic       pc_raw;
    logic       lo_raw;
    logic       hi_raw;
    logic       acl_raw;
    logic       ill_raw;
    logic       mem_cyc;

    assign aaa    = ir[7:5];
    assign bbb    = ir[4:2];
    assign cc     = ir[1:0];
    assign grp    = (cc == 2'b01) && (aaa <= 3'd5);
    assign is_imm = grp && (bbb == 3'b010) && (ir != 8'h89);
    assign is_zp  = grp && (bbb == 3'b001);
    assign is_abs = grp && (bbb == 3'b011);
    assign is_sta = (aaa == 3'b100);
    assign is_nop = (ir == 8'hEA);

    always_comb begin
        case (aaa)
            3'b000:  alu_sel = 3'b100;
            3'b001:  alu_sel = 3'b010;
            3'b010:  alu_sel = 3'b011;
            3'b011:  alu_sel = 3'b001;
            3'b101:  alu_sel = 3'b101;
            default: alu_sel = 3'b000;
        endcase
    end

    always_comb begin
        state_nxt = T1;
        sync      = 1'b0;
        rw        = 1'b1;
        ab_sel    = 2'b00;
        alu_op    = 3'b000;
        ac_db     = 1'b0;
        pc_raw    = 1'b0;
        lo_raw    = 1'b0;
        hi_raw    = 1'b0;
        acl_raw   = 1'b0;
        ill_raw   = 1'b0;
        mem_cyc   = 1'b0;
        case (state)
            T1: begin
                sync      = 1'b1;
                pc_raw    = 1'b1;
                state_nxt = T2;
            end
            T2: begin
                if (is_imm) begin
                    pc_raw  = 1'b1;
                    alu_op  = alu_sel;
                    acl_raw = 1'b1;
                end else if (is_zp || is_abs) begin
                    pc_raw    = 1'b1;
                    lo_raw    = 1'b1;
                    state_nxt = T3;
                end else if (!is_nop) begin
                    ill_raw = 1'b1;
                end
            end
            T3: begin
                if (is_zp) begin
                    ab_sel  = 2'b01;
                    mem_cyc = 1'b1;
                end else if (is_abs) begin
                    pc_raw    = 1'b1;
                    hi_raw    = 1'b1;
                    state_nxt = T4;
                end
            end
            T4: begin
                if (is_abs) begin
                    ab_sel  = 2'b10;
                    mem_cyc = 1'b1;
                end
            end
            default: state_nxt = T1;
        endcase

        // Memory access cycle: stores drive the accumulator, everything else loads it.
        if (mem_cyc) begin
            if (is_sta) begin
                rw    = 1'b0;
                ac_db = 1'b1;
            end else begin
                alu_op  = alu_sel;
                acl_raw = 1'b1;
            end
        end

        if (rst) begin
            rw    = 1'b1;
            ac_db = 1'b0;
        end

        stall   = rw && !rdy;
        pc_inc  = pc_raw  && !stall && !rst;
        lo_ld   = lo_raw  && !stall && !rst;
        hi_ld   = hi_raw  && !stall && !rst;
        ac_load = acl_raw && !stall && !rst;
        illegal = ill_raw && !stall && !rst;
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            state <= T1;
            ir    <= 8'hEA;
        end else if (!stall) begin
            state <= state_nxt;
            if (state == T1) begin
                ir <= data_in;
            end
        end
    end

    assign t_state = state;

endmodule

// File: tb/tb_timing_control.sv
// Self-checking bench for timing_control: directed scenarios plus randomized
// instruction streams with random stalls checked against a per-cycle model.
module tb_timing_control;

    logic       phi2 = 1'b0;
    logic       rst;
    logic       rdy;
    logic [7:0] data_in;
    logic [2:0] t_state;
    logic [7:0] ir;
    logic       sync;
    logic       rw;
    logic [1:0] ab_sel;
    logic       pc_inc;
    logic       lo_ld;
    logic       hi_ld;
    logic [2:0] alu_op;
    logic       ac_load;
    logic       ac_db;
    logic       illegal;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] cur_ir;
    logic [7:0] legal_ops[$];

    timing_control dut (
        .phi2    (phi2),
        .rst     (rst),
        .rdy     (rdy),
        .data_in (data_in),
        .t_state (t_state),
        .ir      (ir),
        .sync    (sync),
        .rw      (rw),
        .ab_sel  (ab_sel),
        .pc_inc  (pc_inc),
        .lo_ld   (lo_ld),
        .hi_ld   (hi_ld),
        .alu_op  (alu_op),
        .ac_load (ac_load),
        .ac_db   (ac_db),
        .illegal (illegal)
    );

    always #5 phi2 = ~phi2;

    // Vector layout: {t, sync, rw, ab_sel, pc_inc, lo_ld, hi_ld, alu_op, ac_load, ac_db, illegal}
    function automatic logic [15:0] mk(input logic [2:0] t, input logic s, input logic w,
                                       input logic [1:0] ab, input logic pc, input logic lo,
                                       input logic hi, input logic [2:0] alu, input logic acl,
                                       input logic acdb, input logic ill);
        return {t, s, w, ab, pc, lo, hi, alu, acl, acdb, ill};
    endfunction

    function automatic logic [15:0] outs();
        return {t_state, sync, rw, ab_sel, pc_inc, lo_ld, hi_ld, alu_op, ac_load, ac_db, illegal};
    endfunction

    // 0=imm 1=zp 2=abs 3=nop 4=illegal
    function automatic int mode_of(input logic [7:0] op);
        if (op == 8'hEA) return 3;
        if (op[1:0] != 2'b01 || op[7:5] > 3'd5 || op == 8'h89) return 4;
        case (op[4:2])
            3'd2:    return 0;
            3'd1:    return 1;
            3'd3:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int n_cycles(input logic [7:0] op);
        case (mode_of(op))
            0:       return 2;
            1:       return 3;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [7:0] op);
        case (op[7:5])
            3'd0:    return 3'b100;
            3'd1:    return 3'b010;
            3'd2:    return 3'b011;
            3'd3:    return 3'b001;
            3'd5:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs for cycle n (1-based) of instruction op.
    function automatic logic [15:0] expv(input logic [7:0] op, input int n, input logic stalled);
        logic       s = 1'b0, w = 1'b1, pc = 1'b0, lo = 1'b0, hi = 1'b0;
        logic       acl = 1'b0, acdb = 1'b0, ill = 1'b0, mem = 1'b0;
        logic [1:0] ab = 2'b00;
        logic [2:0] alu = 3'b000;
        int         m = mode_of(op);
        if (n == 1) begin
            s = 1'b1; pc = 1'b1;
        end else if (m == 0) begin
            pc = 1'b1; alu = alu_of(op); acl = 1'b1;
        end else if (m == 1) begin
            if (n == 2) begin pc = 1'b1; lo = 1'b1; end
            else begin ab = 2'b01; mem = 1'b1; end
        end else if (m == 2) begin
            if (n == 2) begin pc = 1'b1; lo = 1'b1; end
            else if (n == 3) begin pc = 1'b1; hi = 1'b1; end
            else begin ab = 2'b10; mem = 1'b1; end
        end else if (m == 4) begin
            ill = 1'b1;
        end
        if (mem) begin
            if (op[7:5] == 3'd4) begin w = 1'b0; acdb = 1'b1; end
            else begin alu = alu_of(op); acl = 1'b1; end
        end
        if (stalled && w) begin
            pc = 1'b0; lo = 1'b0; hi = 1'b0; acl = 1'b0; ill = 1'b0;
        end
        return mk(3'(n), s, w, ab, pc, lo, hi, alu, acl, acdb, ill);
    endfunction

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; data_in = 8'hFF;
        @(negedge phi2); @(negedge phi2); #1;
        n_checks++;
        if (t_state !== 3'd1 || ir !== 8'hEA) begin
            n_fail++; $display("FAIL reset_state: got t=%0d ir=%h want t=1 ir=ea", t_state, ir);
        end
        n_checks++;
        if ({pc_inc, lo_ld, hi_ld, ac_load, ac_db, illegal, rw} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 0000001", {pc_inc, lo_ld, hi_ld, ac_load, ac_db, illegal, rw});
        end
        rst = 1'b0; rdy = 1'b0; #1;
        n_checks++;
        if (sync !== 1'b1 || pc_inc !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_rdy0: got sync=%b pc_inc=%b want 1 0", sync, pc_inc);
        end
        rdy = 1'b1; #1;
        n_checks++;
        if (outs() !== mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL post_reset_rdy1: got %h want %h", outs(), mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_lda_imm();
        data_in = 8'hA9; rdy = 1'b1; #1;
        n_checks++;
        if (outs() !== mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL lda_t1: got %h want %h", outs(), mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        end
        @(negedge phi2); data_in = 8'h5A; #1;
        n_checks++;
        if (outs() !== mk(2, 0, 1, 0, 1, 0, 0, 3'b101, 1, 0, 0) || ir !== 8'hA9) begin
            n_fail++; $display("FAIL lda_t2: got %h ir=%h want %h ir=a9", outs(), ir, mk(2, 0, 1, 0, 1, 0, 0, 3'b101, 1, 0, 0));
        end
        @(negedge phi2); #1;
        n_checks++;
        if (outs() !== mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL lda_next_t1: got %h want %h", outs(), mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_sta_abs();
        data_in = 8'h8D; rdy = 1'b1;
        @(negedge phi2); data_in = 8'h00; #1;
        n_checks++;
        if (outs() !== mk(2, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL sta_abs_t2: got %h want %h", outs(), mk(2, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        end
        @(negedge phi2); data_in = 8'h20; #1;
        n_checks++;
        if (outs() !== mk(3, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL sta_abs_t3: got %h want %h", outs(), mk(3, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0));
        end
        @(negedge phi2); #1;
        n_checks++;
        if (outs() !== mk(4, 0, 0, 2'b10, 0, 0, 0, 0, 0, 1, 0)) begin
            n_fail++; $display("FAIL sta_abs_t4: got %h want %h", outs(), mk(4, 0, 0, 2'b10, 0, 0, 0, 0, 0, 1, 0));
        end
        @(negedge phi2); data_in = 8'hEA; #1;
        n_checks++;
        if (outs() !== mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0) || ir !== 8'h8D) begin
            n_fail++; $display("FAIL sta_abs_t1: got %h ir=%h want %h ir=8d", outs(), ir, mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_adc_zp_stall();
        data_in = 8'h65; rdy = 1'b1;
        @(negedge phi2); data_in = 8'h10; #1;
        n_checks++;
        if (outs() !== mk(2, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL adc_zp_t2: got %h want %h", outs(), mk(2, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge phi2); rdy = 1'b0; #1;
            n_checks++;
            if (outs() !== mk(3, 0, 1, 2'b01, 0, 0, 0, 3'b001, 0, 0, 0)) begin
                n_fail++; $display("FAIL adc_zp_stall%0d: got %h want %h", k, outs(), mk(3, 0, 1, 2'b01, 0, 0, 0, 3'b001, 0, 0, 0));
            end
        end
        rdy = 1'b1; #1;
        n_checks++;
        if (outs() !== mk(3, 0, 1, 2'b01, 0, 0, 0, 3'b001, 1, 0, 0)) begin
            n_fail++; $display("FAIL adc_zp_t3: got %h want %h", outs(), mk(3, 0, 1, 2'b01, 0, 0, 0, 3'b001, 1, 0, 0));
        end
        @(negedge phi2); #1;
        n_checks++;
        if (outs() !== mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL adc_zp_t1: got %h want %h", outs(), mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_sta_zp_write();
        data_in = 8'h85; rdy = 1'b1;
        @(negedge phi2); data_in = 8'h10;
        @(negedge phi2); rdy = 1'b0; #1;
        n_checks++;
        if (outs() !== mk(3, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0)) begin
            n_fail++; $display("FAIL sta_zp_t3: got %h want %h", outs(), mk(3, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0));
        end
        @(negedge phi2); rdy = 1'b1; #1;
        n_checks++;
        if (outs() !== mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL sta_zp_t1: got %h want %h", outs(), mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_illegal();
        data_in = 8'h02; rdy = 1'b1;
        @(negedge phi2); data_in = 8'h33; #1;
        n_checks++;
        if (outs() !== mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1)) begin
            n_fail++; $display("FAIL illegal_t2: got %h want %h", outs(), mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        @(negedge phi2); #1;
        n_checks++;
        if (outs() !== mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL illegal_t1: got %h want %h", outs(), mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset_mid();
        data_in = 8'h2D; rdy = 1'b1;
        @(negedge phi2); data_in = 8'h34;
        @(negedge phi2); data_in = 8'h12; #1;
        n_checks++;
        if (outs() !== mk(3, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL and_abs_t3: got %h want %h", outs(), mk(3, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0));
        end
        rst = 1'b1; #1;
        n_checks++;
        if ({pc_inc, lo_ld, hi_ld, ac_load, ac_db, illegal, rw} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL mid_reset_outs: got %b want 0000001", {pc_inc, lo_ld, hi_ld, ac_load, ac_db, illegal, rw});
        end
        @(negedge phi2); rst = 1'b0; data_in = 8'hA9; #1;
        n_checks++;
        if (outs() !== mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0) || ir !== 8'hEA) begin
            n_fail++; $display("FAIL mid_reset_t1: got %h ir=%h want %h ir=ea", outs(), ir, mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        end
        @(negedge phi2); data_in = 8'h11; #1;
        n_checks++;
        if (outs() !== mk(2, 0, 1, 0, 1, 0, 0, 3'b101, 1, 0, 0) || ir !== 8'hA9) begin
            n_fail++; $display("FAIL mid_reset_fetch: got %h ir=%h want %h ir=a9", outs(), ir, mk(2, 0, 1, 0, 1, 0, 0, 3'b101, 1, 0, 0));
        end
        @(negedge phi2);
        cur_ir = 8'hA9;
    endtask

    task automatic test_random();
        logic [7:0]  op;
        logic [15:0] e;
        int          nc;
        int          stalls;
        for (int a = 0; a < 6; a++) begin
            for (int b = 1; b < 4; b++) begin
                op = 8'((a << 5) | (b << 2) | 1);
                if (op != 8'h89) legal_ops.push_back(op);
            end
        end
        legal_ops.push_back(8'hEA);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 6) op = legal_ops[$urandom_range(0, legal_ops.size() - 1)];
            else op = 8'($urandom_range(0, 255));
            nc = n_cycles(op);
            for (int n = 1; n <= nc; n++) begin
                e = expv(op, n, 1'b0);
                stalls = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                if (e[11] == 1'b1) begin
                    for (int s = 0; s < stalls; s++) begin
                        rdy = 1'b0; data_in = 8'($urandom_range(0, 255)); #1;
                        n_checks++;
                        if (outs() !== expv(op, n, 1'b1) || ir !== ((n == 1) ? cur_ir : op)) begin
                            n_fail++;
                            $display("FAIL rand_stall op=%h cyc=%0d: got %h ir=%h want %h ir=%h",
                                     op, n, outs(), ir, expv(op, n, 1'b1), (n == 1) ? cur_ir : op);
                        end
                        @(negedge phi2);
                    end
                    rdy = 1'b1;
                end else begin
                    rdy = 1'($urandom_range(0, 1));
                end
                data_in = (n == 1) ? op : 8'($urandom_range(0, 255)); #1;
                n_checks++;
                if (outs() !== e || ir !== ((n == 1) ? cur_ir : op)) begin
                    n_fail++;
                    $display("FAIL rand_cycle op=%h cyc=%0d: got %h ir=%h want %h ir=%h",
                             op, n, outs(), ir, e, (n == 1) ? cur_ir : op);
                end
                @(negedge phi2);
                if (n == 1) cur_ir = op;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; data_in = 8'h00; cur_ir = 8'hEA;
        test_reset();
        test_lda_imm();
        test_sta_abs();
        test_adc_zp_stall();
        test_sta_zp_write();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
